// File: rtl/mul_product_accumulator_if.sv
// Product-in / sum-out handshake bundle for mul_product_accumulator.
// Ports: prod_vld/prod_rdy/prod/signed_mul/prod_last in, acc_vld/acc_rdy/acc/acc_signed/acc_err out.
interface mul_product_accumulator_if #(
    parameter int n  = 8,
    parameter int aw = 20
);
    logic            prod_vld;
    logic            prod_rdy;
    logic [2*n-1:0]  prod;
    logic            signed_mul;
    logic            prod_last;
    logic            acc_vld;
    logic            acc_rdy;
    logic [aw-1:0]   acc;
    logic            acc_signed;
    logic            acc_err;

    modport master (
        output prod_vld, prod, signed_mul, prod_last, acc_rdy,
        input  prod_rdy, acc_vld, acc, acc_signed, acc_err
    );

    modport slave (
        input  prod_vld, prod, signed_mul, prod_last, acc_rdy,
        output prod_rdy, acc_vld, acc, acc_signed, acc_err
    );
endinterface

// File: rtl/mul_product_accumulator.sv
// Sums a frame of 2n-bit multiplier products into an aw-bit accumulator, one sum per frame.
// Ports: clk, rst (sync, active-high), bus (slave side of mul_product_accumulator_if).
module mul_product_accumulator #(
    parameter int n       = 8,
    parameter int max_len = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    mul_product_accumulator_if.slave bus
);
    localparam int aw = 2*n + $clog2(max_len);
    localparam int cw = $clog2(max_len + 1);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t          state_q, state_d;
    logic [aw-1:0]   acc_q, acc_d;
    logic [cw-1:0]   cnt_q, cnt_d;
    logic            sgn_q, sgn_d;
    logic            err_q, err_d;
    logic            vld_q, vld_d;
    logic [cw-1:0]   cnt_inc;
    logic            take;

    function automatic logic [aw-1:0] ext(input logic [2*n-1:0] p, input logic s);
        ext = s ? {{(aw-2*n){p[2*n-1]}}, p} : {{(aw-2*n){1'b0}}, p};
    endfunction

    assign bus.prod_rdy   = (state_q != OUT);
    assign bus.acc_vld    = vld_q;
    assign bus.acc        = acc_q;
    assign bus.acc_signed = sgn_q;
    assign bus.acc_err    = err_q;

    assign take    = bus.prod_vld && (state_q != OUT);
    assign cnt_inc = cnt_q + cw'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    acc_d   = ext(bus.prod, bus.signed_mul);
                    sgn_d   = bus.signed_mul;
                    err_d   = 1'b0;
                    cnt_d   = cw'(1);
                    state_d = bus.prod_last ? OUT : ACC;
                end
            end
            ACC: begin
                if (take) begin
                    // Frame signedness is fixed by its first beat.
                    acc_d = acc_q + ext(bus.prod, sgn_q);
                    cnt_d = cnt_inc;
                    if (bus.signed_mul != sgn_q)
                        err_d = 1'b1;
                    if (bus.prod_last) begin
                        state_d = OUT;
                    end else if (cnt_inc == cw'(max_len)) begin
                        state_d = OUT;
                        err_d   = 1'b1;
                    end
                end
            end
            OUT: begin
                if (bus.acc_rdy) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        vld_d = (state_d == OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
        end
    end
endmodule

// File: tb/tb_mul_product_accumulator.sv
// Directed bench for mul_product_accumulator (n=8, max_len=4, aw=18).
// Ports: none; drives the DUT through mul_product_accumulator_if.
module tb_mul_product_accumulator;
    localparam int N  = 8;
    localparam int ML = 4;
    localparam int AW = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_product_accumulator_if #(.n(N), .aw(AW)) bus ();

    mul_product_accumulator #(.n(N), .max_len(ML)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0][15:0] p;
        logic [3:0]       s;
        logic [3:0]       l;
        logic [2:0]       nb;
        logic [AW-1:0]    ea;
        logic             es;
        logic             ee;
    } vec_t;

    int checks = 0;
    int failures = 0;
    vec_t tv [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int nb,
                                input logic [15:0] p0, p1, p2, p3,
                                input logic [3:0] s, l,
                                input logic [AW-1:0] ea,
                                input logic es, ee);
        vec_t v;
        v.p  = {p3, p2, p1, p0};
        v.s  = s;
        v.l  = l;
        v.nb = 3'(nb);
        v.ea = ea;
        v.es = es;
        v.ee = ee;
        return v;
    endfunction

    task automatic send_beat(input logic [15:0] p, input logic s, input logic l);
        @(negedge clk);
        check("rdy_before_beat", 32'(bus.prod_rdy), 32'd1);
        check("vld_low_mid_frame", 32'(bus.acc_vld), 32'd0);
        bus.prod_vld   = 1'b1;
        bus.prod       = p;
        bus.signed_mul = s;
        bus.prod_last  = l;
    endtask

    task automatic expect_sum(input string tag, input logic [AW-1:0] ea,
                              input logic es, input logic ee);
        @(negedge clk);
        bus.prod_vld  = 1'b0;
        bus.prod_last = 1'b0;
        check({tag, "_vld"}, 32'(bus.acc_vld), 32'd1);
        check({tag, "_acc"}, 32'(bus.acc), 32'(ea));
        check({tag, "_sgn"}, 32'(bus.acc_signed), 32'(es));
        check({tag, "_err"}, 32'(bus.acc_err), 32'(ee));
        check({tag, "_rdy0"}, 32'(bus.prod_rdy), 32'd0);
        bus.acc_rdy = 1'b1;
        @(negedge clk);
        bus.acc_rdy = 1'b0;
        check({tag, "_vld_drop"}, 32'(bus.acc_vld), 32'd0);
        check({tag, "_rdy1"}, 32'(bus.prod_rdy), 32'd1);
    endtask

    initial begin
        tv[0] = mk(4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'b0000, 4'b1000, 18'h3FFFC, 1'b0, 1'b0);
        tv[1] = mk(2, 16'h4000, 16'hFFFB, 16'h0, 16'h0, 4'b0011, 4'b0010, 18'h03FFB, 1'b1, 1'b0);
        tv[2] = mk(1, 16'h8000, 16'h0, 16'h0, 16'h0, 4'b0001, 4'b0001, 18'h38000, 1'b1, 1'b0);
        tv[3] = mk(4, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 4'b0000, 4'b0000, 18'h00004, 1'b0, 1'b1);
        tv[4] = mk(1, 16'h0002, 16'h0, 16'h0, 16'h0, 4'b0000, 4'b0001, 18'h00002, 1'b0, 1'b0);
        tv[5] = mk(2, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 4'b0001, 4'b0010, 18'h3FFFE, 1'b1, 1'b1);
        tv[6] = mk(2, 16'h8000, 16'h8000, 16'h0, 16'h0, 4'b0000, 4'b0010, 18'h10000, 1'b0, 1'b0);
        tv[7] = mk(3, 16'h7FFF, 16'h8000, 16'h0001, 16'h0, 4'b0111, 4'b0100, 18'h00000, 1'b1, 1'b0);

        bus.prod_vld   = 1'b0;
        bus.prod       = '0;
        bus.signed_mul = 1'b0;
        bus.prod_last  = 1'b0;
        bus.acc_rdy    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_acc", 32'(bus.acc), 32'd0);
        check("rst_vld", 32'(bus.acc_vld), 32'd0);
        check("rst_sgn", 32'(bus.acc_signed), 32'd0);
        check("rst_err", 32'(bus.acc_err), 32'd0);
        check("rst_rdy", 32'(bus.prod_rdy), 32'd1);

        for (int i = 0; i < 8; i++) begin
            for (int b = 0; b < int'(tv[i].nb); b++)
                send_beat(tv[i].p[b], tv[i].s[b], tv[i].l[b]);
            expect_sum($sformatf("vec%0d", i), tv[i].ea, tv[i].es, tv[i].ee);
        end

        // Backpressure: sum must hold and no beat may be taken.
        send_beat(16'h0003, 1'b0, 1'b1);
        @(negedge clk);
        bus.prod       = 16'h0100;
        bus.prod_last  = 1'b1;
        check("bp_vld_rise", 32'(bus.acc_vld), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_acc", 32'(bus.acc), 32'd3);
            check("bp_vld", 32'(bus.acc_vld), 32'd1);
            check("bp_rdy", 32'(bus.prod_rdy), 32'd0);
        end
        expect_sum("bp", 18'd3, 1'b0, 1'b0);

        // Reset mid-frame discards the partial sum.
        send_beat(16'h0010, 1'b1, 1'b0);
        send_beat(16'h0020, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.prod_vld = 1'b0;
        check("mid_rst_acc", 32'(bus.acc), 32'd0);
        check("mid_rst_vld", 32'(bus.acc_vld), 32'd0);
        check("mid_rst_sgn", 32'(bus.acc_signed), 32'd0);
        check("mid_rst_err", 32'(bus.acc_err), 32'd0);
        check("mid_rst_rdy", 32'(bus.prod_rdy), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_quiet", 32'(bus.acc_vld), 32'd0);
        end
        // Count restarted: 3 beats must not force a close.
        send_beat(16'h0005, 1'b0, 1'b0);
        send_beat(16'h0006, 1'b0, 1'b0);
        send_beat(16'h0007, 1'b0, 1'b1);
        expect_sum("post_rst", 18'd18, 1'b0, 1'b0);

        // Reset while a sum is waiting.
        send_beat(16'h0009, 1'b0, 1'b1);
        @(negedge clk);
        bus.prod_vld = 1'b0;
        check("out_rst_pre", 32'(bus.acc_vld), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("out_rst_vld", 32'(bus.acc_vld), 32'd0);
        check("out_rst_acc", 32'(bus.acc), 32'd0);
        check("out_rst_rdy", 32'(bus.prod_rdy), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
